// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bundle between the DMA register/pin logic and the priority arbiter.
// The master drives the request side; the slave (arbiter) drives the hold handshake and grant.
interface dma_priority_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0] DREQ;
    logic              DREQ_POL;
    logic              DACK_POL;
    logic              ROT_PRI;
    logic              CTRL_DIS;
    logic [NUM_CH-1:0] MASK;
    logic [NUM_CH-1:0] SW_REQ;
    logic              HLDA;
    logic              EOP_DONE;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic [CH_W-1:0]   ACTIVE_CH;
    logic              CH_VALID;
    logic [NUM_CH-1:0] REQ_STATUS;

    modport master (
        output DREQ, DREQ_POL, DACK_POL, ROT_PRI, CTRL_DIS, MASK, SW_REQ, HLDA, EOP_DONE,
        input  HRQ, DACK, ACTIVE_CH, CH_VALID, REQ_STATUS
    );

    modport slave (
        input  DREQ, DREQ_POL, DACK_POL, ROT_PRI, CTRL_DIS, MASK, SW_REQ, HLDA, EOP_DONE,
        output HRQ, DACK, ACTIVE_CH, CH_VALID, REQ_STATUS
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 8237A-style DREQ conditioning, fixed/rotating priority and HRQ/HLDA handshake.
// DREQ registered once (HRQ two edges after DREQ); grant one edge after HLDA; no backpressure beyond HLDA.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    dma_priority_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_n;
    logic [NUM_CH-1:0] dreq_r, dreq_n;
    logic [NUM_CH-1:0] dack_raw_q, dack_raw_n;
    logic [CH_W-1:0]   active_q, active_n;
    logic [CH_W-1:0]   top_q, top_n;
    logic              hrq_q, hrq_n;
    logic              ch_valid_q, ch_valid_n;

    logic [NUM_CH-1:0] pending;
    logic [CH_W-1:0]   winner;
    logic [CH_W-1:0]   idx;
    logic              found;

    assign dreq_n  = bus.DREQ_POL ? ~bus.DREQ : bus.DREQ;
    assign pending = (dreq_r & ~bus.MASK) | bus.SW_REQ;

    // Search order top, top+1, ... relies on CH_W-bit addition wrapping mod 4.
    always_comb begin
        winner = top_q;
        found  = 1'b0;
        idx    = top_q;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = top_q + CH_W'(i);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            dreq_r     <= '0;
            dack_raw_q <= '0;
            active_q   <= '0;
            top_q      <= '0;
            hrq_q      <= 1'b0;
            ch_valid_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            dreq_r     <= dreq_n;
            dack_raw_q <= dack_raw_n;
            active_q   <= active_n;
            top_q      <= top_n;
            hrq_q      <= hrq_n;
            ch_valid_q <= ch_valid_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        hrq_n      = hrq_q;
        ch_valid_n = ch_valid_q;
        dack_raw_n = dack_raw_q;
        active_n   = active_q;
        top_n      = bus.ROT_PRI ? top_q : '0;

        unique case (state_q)
            IDLE: begin
                hrq_n      = 1'b0;
                ch_valid_n = 1'b0;
                dack_raw_n = '0;
                if (pending != '0 && !bus.CTRL_DIS) begin
                    state_n = REQ;
                    hrq_n   = 1'b1;
                end
            end
            REQ: begin
                if (pending == '0 || bus.CTRL_DIS) begin
                    state_n = IDLE;
                    hrq_n   = 1'b0;
                end else if (bus.HLDA) begin
                    state_n            = SERVICE;
                    active_n           = winner;
                    ch_valid_n         = 1'b1;
                    dack_raw_n         = '0;
                    dack_raw_n[winner] = 1'b1;
                end
            end
            SERVICE: begin
                // EOP wins over a simultaneous HLDA drop so the rotation is not lost.
                if (bus.EOP_DONE || !bus.HLDA) begin
                    state_n    = RELEASE;
                    hrq_n      = 1'b0;
                    ch_valid_n = 1'b0;
                    dack_raw_n = '0;
                    if (bus.EOP_DONE && bus.ROT_PRI) begin
                        top_n = active_q + CH_W'(1);
                    end
                end
            end
            RELEASE: begin
                state_n    = IDLE;
                hrq_n      = 1'b0;
                ch_valid_n = 1'b0;
                dack_raw_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.HRQ        = hrq_q;
    assign bus.CH_VALID   = ch_valid_q;
    assign bus.ACTIVE_CH  = active_q;
    assign bus.DACK       = bus.DACK_POL ? dack_raw_q : ~dack_raw_q;
    assign bus.REQ_STATUS = dreq_r | bus.SW_REQ;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: fixed/rotating priority, polarity, mask/software request,
// late arrival, withdrawal, HLDA abort and mid-service reset.
module tb_dma_priority_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    dma_priority_arbiter_if #(.NUM_CH(4), .CH_W(2)) bus ();

    dma_priority_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it; inputs are then changed and outputs sampled here.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.DREQ = 4'b0000;  bus.DREQ_POL = 1'b0; bus.DACK_POL = 1'b0;
        bus.ROT_PRI = 1'b0;  bus.CTRL_DIS = 1'b0; bus.MASK = 4'b0000;
        bus.SW_REQ = 4'b0000; bus.HLDA = 1'b0;    bus.EOP_DONE = 1'b0;
        tick(2);
        chk("rst_hrq",    {7'd0, bus.HRQ},      8'h0);
        chk("rst_dack",   {4'd0, bus.DACK},     8'hF);
        chk("rst_valid",  {7'd0, bus.CH_VALID}, 8'h0);
        chk("rst_active", {6'd0, bus.ACTIVE_CH}, 8'h0);
        chk("rst_status", {4'd0, bus.REQ_STATUS}, 8'h0);

        // Fixed priority: ch1 beats ch3, then ch3 after release
        rst_n = 1'b1;
        bus.DREQ = 4'b1010;
        tick();
        chk("fix_status", {4'd0, bus.REQ_STATUS}, 8'hA);
        chk("fix_hrq_e1", {7'd0, bus.HRQ}, 8'h0);
        tick();
        chk("fix_hrq_e2", {7'd0, bus.HRQ}, 8'h1);
        tick(2);
        bus.HLDA = 1'b1;
        tick();
        chk("fix_valid",  {7'd0, bus.CH_VALID}, 8'h1);
        chk("fix_active", {6'd0, bus.ACTIVE_CH}, 8'h1);
        chk("fix_dack",   {4'd0, bus.DACK}, 8'hD);
        tick();
        bus.EOP_DONE = 1'b1;
        bus.DREQ = 4'b1000;
        tick();
        bus.EOP_DONE = 1'b0;
        chk("fix_rel_hrq",  {7'd0, bus.HRQ}, 8'h0);
        chk("fix_rel_dack", {4'd0, bus.DACK}, 8'hF);
        tick();
        chk("fix_idle_hrq", {7'd0, bus.HRQ}, 8'h0);
        tick();
        chk("fix_rehrq", {7'd0, bus.HRQ}, 8'h1);
        tick();
        chk("fix_ch3",      {6'd0, bus.ACTIVE_CH}, 8'h3);
        chk("fix_ch3_dack", {4'd0, bus.DACK}, 8'h7);
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b0000;
        tick(3);

        // Rotating priority: ch1, then all requesting -> ch2, ch3, ch0
        bus.ROT_PRI = 1'b1;
        bus.DREQ = 4'b0010;
        tick(2);
        bus.HLDA = 1'b1;
        tick();
        chk("rot_ch1", {6'd0, bus.ACTIVE_CH}, 8'h1);
        bus.DREQ = 4'b1111;
        bus.EOP_DONE = 1'b1;
        tick();
        bus.EOP_DONE = 1'b0;
        tick(3);
        chk("rot_ch2", {6'd0, bus.ACTIVE_CH}, 8'h2);
        bus.EOP_DONE = 1'b1;
        tick();
        bus.EOP_DONE = 1'b0;
        tick(3);
        chk("rot_ch3", {6'd0, bus.ACTIVE_CH}, 8'h3);
        bus.EOP_DONE = 1'b1;
        tick();
        bus.EOP_DONE = 1'b0;
        tick(3);
        chk("rot_wrap_ch0", {6'd0, bus.ACTIVE_CH}, 8'h0);
        chk("rot_valid",    {7'd0, bus.CH_VALID}, 8'h1);

        // HLDA abort: release without rotation, so ch0 wins again
        bus.HLDA = 1'b0;
        tick();
        chk("abort_hrq",   {7'd0, bus.HRQ}, 8'h0);
        chk("abort_valid", {7'd0, bus.CH_VALID}, 8'h0);
        bus.HLDA = 1'b1;
        tick(3);
        chk("abort_top_kept", {6'd0, bus.ACTIVE_CH}, 8'h0);
        bus.DREQ = 4'b0000;
        bus.HLDA = 1'b0;
        bus.ROT_PRI = 1'b0;
        tick(3);

        // Polarity: active-low DREQ, active-high DACK
        bus.DREQ_POL = 1'b1;
        bus.DACK_POL = 1'b1;
        bus.DREQ = 4'b1110;
        tick();
        chk("pol_status",    {4'd0, bus.REQ_STATUS}, 8'h1);
        chk("pol_idle_dack", {4'd0, bus.DACK}, 8'h0);
        tick();
        bus.HLDA = 1'b1;
        tick();
        chk("pol_active", {6'd0, bus.ACTIVE_CH}, 8'h0);
        chk("pol_dack",   {4'd0, bus.DACK}, 8'h1);
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b1111;
        tick(2);
        bus.DREQ_POL = 1'b0;
        bus.DACK_POL = 1'b0;
        bus.DREQ = 4'b0000;
        tick(2);

        // Mask blocks hardware request; software request bypasses mask
        bus.MASK = 4'b0001;
        bus.DREQ = 4'b0001;
        tick(3);
        chk("mask_hrq",    {7'd0, bus.HRQ}, 8'h0);
        chk("mask_status", {4'd0, bus.REQ_STATUS}, 8'h1);
        bus.SW_REQ = 4'b0001;
        tick(2);
        chk("swreq_hrq", {7'd0, bus.HRQ}, 8'h1);
        bus.HLDA = 1'b1;
        tick();
        chk("swreq_valid",  {7'd0, bus.CH_VALID}, 8'h1);
        chk("swreq_active", {6'd0, bus.ACTIVE_CH}, 8'h0);
        bus.HLDA = 1'b0;
        bus.SW_REQ = 4'b0000;
        bus.MASK = 4'b0000;
        bus.DREQ = 4'b0000;
        tick(3);

        // Late higher-priority arrival before HLDA wins
        bus.DREQ = 4'b0100;
        tick(2);
        chk("late_hrq", {7'd0, bus.HRQ}, 8'h1);
        bus.DREQ = 4'b0101;
        tick();
        bus.HLDA = 1'b1;
        tick();
        chk("late_ch0", {6'd0, bus.ACTIVE_CH}, 8'h0);
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b0000;
        tick(3);

        // Withdrawal in REQ drops HRQ
        bus.DREQ = 4'b0100;
        tick(2);
        bus.DREQ = 4'b0000;
        tick();
        chk("wd_hrq_hold", {7'd0, bus.HRQ}, 8'h1);
        tick();
        chk("wd_hrq_drop", {7'd0, bus.HRQ}, 8'h0);

        // Controller disable blocks arbitration
        bus.CTRL_DIS = 1'b1;
        bus.DREQ = 4'b0001;
        tick(3);
        chk("dis_hrq", {7'd0, bus.HRQ}, 8'h0);
        bus.CTRL_DIS = 1'b0;
        bus.DREQ = 4'b0000;
        tick(2);

        // Reset mid-service
        bus.DREQ = 4'b0100;
        tick(2);
        bus.HLDA = 1'b1;
        tick();
        chk("svc_active", {6'd0, bus.ACTIVE_CH}, 8'h2);
        rst_n = 1'b0;
        tick();
        chk("mrst_hrq",    {7'd0, bus.HRQ}, 8'h0);
        chk("mrst_dack",   {4'd0, bus.DACK}, 8'hF);
        chk("mrst_valid",  {7'd0, bus.CH_VALID}, 8'h0);
        chk("mrst_active", {6'd0, bus.ACTIVE_CH}, 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Request/priority stage of the 8237A-style DMA controller.
- Conditions the four DREQ inputs (polarity, mask, software request) and arbitrates between them using fixed or rotating priority.
- Runs the HRQ/HLDA bus handshake with the CPU and drives the channel DACK.
- Hands the granted channel to the timing/control FSM downstream and takes its end-of-service pulse back.

Parameters:
NUM_CH, 4, number of DMA channels; the block is defined for 4 only.
CH_W, 2, width of the channel index.

Ports:
CLK  in  1  system clock; all state updates on rising edge
RESET_N  in  1  synchronous active-low reset
DREQ  in  NUM_CH  raw channel request pins
DREQ_POL  in  1  command bit 6: 0 = DREQ active high, 1 = active low
DACK_POL  in  1  command bit 7: 0 = DACK active low, 1 = active high
ROT_PRI  in  1  command bit 4: 0 = fixed priority (ch0 highest), 1 = rotating
CTRL_DIS  in  1  command bit 2: controller disable; blocks new arbitration
MASK  in  NUM_CH  mask register; 1 = hardware DREQ ignored
SW_REQ  in  NUM_CH  software request register; not affected by MASK
HLDA  in  1  hold acknowledge from CPU
EOP_DONE  in  1  one-cycle pulse from the timing FSM: service of the active channel finished
HRQ  out  1  hold request to CPU
DACK  out  NUM_CH  channel acknowledges, polarity applied
ACTIVE_CH  out  CH_W  index of the channel being serviced
CH_VALID  out  1  1 while ACTIVE_CH is granted (state SERVICE)
REQ_STATUS  out  NUM_CH  status register bits 7:4; current request per channel

Behaviour:
Request conditioning:
- dreq_r <= DREQ_POL ? ~DREQ : DREQ, registered once.
- pending = (dreq_r & ~MASK) | SW_REQ.
- REQ_STATUS = dreq_r | SW_REQ; it ignores MASK and CTRL_DIS.

Priority pointer:
- top (CH_W bits) is the highest-priority channel. Priority order is top, top+1, top+2, top+3, wrapping mod 4.
- When ROT_PRI=0, top is forced to 0 every cycle.
- When ROT_PRI=1 and EOP_DONE is sampled in SERVICE, top <= ACTIVE_CH+1 mod 4, so channel 3 wraps to 0.
- winner = first set bit of pending, searched in priority order from top.

FSM (state register; every output is registered except the DACK polarity stage):
- IDLE: HRQ=0, CH_VALID=0. Moves to REQ when pending != 0 and CTRL_DIS=0. HLDA is ignored in IDLE.
- REQ: HRQ=1.
  - If pending == 0 or CTRL_DIS=1, go to IDLE; HRQ drops on the same edge.
  - Otherwise, if HLDA=1, go to SERVICE and latch ACTIVE_CH <= winner. A higher-priority request that arrives before HLDA therefore wins.
- SERVICE: HRQ=1, CH_VALID=1, dack_raw = onehot(ACTIVE_CH).
  - MASK, DREQ, CTRL_DIS and ROT_PRI changes do not abort service.
  - EOP_DONE=1 goes to RELEASE and applies rotation.
  - HLDA=0 without EOP_DONE goes to RELEASE with no rotation. If both happen in the same cycle, EOP_DONE takes precedence and rotation occurs.
- RELEASE: HRQ=0, CH_VALID=0, dack_raw=0. Lasts exactly one cycle, then returns to IDLE.

DACK output:
- DACK = DACK_POL ? dack_raw : ~dack_raw. This stage is combinational on registered dack_raw.
- The inactive level is therefore 4'hF when DACK_POL=0 and 4'h0 when DACK_POL=1.

Latency:
- DREQ is sampled at edge 1 (into dreq_r) and HRQ=1 after edge 2.
- HLDA sampled high at edge k gives DACK and CH_VALID valid after edge k.
- EOP_DONE sampled at edge m gives DACK inactive and HRQ=0 after edge m.
- The state is IDLE after m+1, and the earliest re-assertion of HRQ is after m+2.

Reset (RESET_N=0 at an edge, from any state including SERVICE):
- state=IDLE, HRQ=0, dack_raw=0 (DACK at its inactive level), CH_VALID=0, ACTIVE_CH=0, top=0, dreq_r=0.

Test Plan:
- Fixed priority: ROT_PRI=0, DREQ=4'b1010, MASK=0, HLDA raised 3 cycles after HRQ → ACTIVE_CH=1 and DACK=4'b1101 (DACK_POL=0); after an EOP_DONE pulse, HRQ=0 for ≥2 cycles, then ch3 is serviced.
- Rotating priority: ROT_PRI=1, service ch1 then pulse EOP_DONE, hold DREQ=4'hF → next grant is ch2, then ch3, then ch0; top wraps 3→0.
- Polarity: DREQ_POL=1, DREQ=4'b1110, DACK_POL=1 → REQ_STATUS=4'b0001, ACTIVE_CH=0, DACK=4'b0001; the idle DACK value is 4'h0.
- Mask and software request: MASK=4'b0001, DREQ=ch0 only → HRQ stays 0 and REQ_STATUS=4'b0001; then SW_REQ=4'b0001 → HRQ=1 two cycles later and ch0 is granted.
- Late arrival and withdrawal: ch2 requests, then ch0 requests while in REQ before HLDA → ch0 granted. Separately, DREQ is withdrawn in REQ → HRQ drops on the next edge and the FSM returns to IDLE.
- Abort and reset: HLDA drops in SERVICE → RELEASE with top unchanged. A separate run pulses RESET_N=0 mid-SERVICE → next cycle HRQ=0, DACK=4'hF, CH_VALID=0, ACTIVE_CH=0.
